fifo_drainmod: RTL and testbench
================================

# fifo_drainmod

Read-side controller for the 1024×16 show-ahead save FIFO in `sdram_basemod`. On each call it drains up to BURST words from the FIFO into a valid/ready stream toward the SDRAM write path. It also keeps a running word address for that path. A burst ends early if the FIFO stays empty for GRACE cycles; the caller gets a one-cycle done pulse plus the delivered word count.

## Interface
Parameters:
- BURST, 8, maximum words per call; legal range 1–256.
- GRACE, 4, consecutive empty cycles tolerated mid-burst before ending it short; legal range 1–255.
- AW, 22, width of the word address.

Ports:
- CLOCK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- iCall  in  1  start one burst; sampled only in IDLE.
- oDone  out  1  one-cycle pulse when the burst finishes.
- iTag  in  2  FIFO status: [1] full, [0] empty.
- iFifoData  in  16  FIFO head word (show-ahead, valid whenever iTag[0]=0).
- oFifoEn  out  1  FIFO read strobe; drives the FIFO's read-enable bit (iEn[0]).
- oData  out  16  stream data.
- oValid  out  1  oData holds an undelivered word.
- iReady  in  1  consumer accepts oData this cycle.
- oCount  out  9  words delivered in the last completed burst.
- oShort  out  1  last burst ended by GRACE expiry with oCount < BURST.
- oAddr  out  AW  word address for the next burst's first word.

## Operation
- FSM states are IDLE, XFER and DONE; reset state is IDLE.
- IDLE:
  - On iCall=1, go to XFER.
  - Clear the issued counter, the delivered counter and the empty counter.
- XFER:
  - Load condition: oFifoEn = (issued < BURST) & !iTag[0] & (!oValid | iReady). It is combinational and asserts only in XFER.
  - On a load edge: oData ← iFifoData, oValid ← 1, issued += 1, empty counter ← 0.
  - On an accept edge (oValid & iReady) with no load: oValid ← 0.
  - Every accept increments the delivered counter.
  - Empty counter: increments on each XFER cycle where issued < BURST, iTag[0]=1 and oValid=0; it saturates at GRACE.
  - Exit to DONE when either:
    - delivered = BURST, or
    - the empty counter reaches GRACE with oValid=0.
  - Whichever condition is met first wins. The delivered counter never exceeds issued.
- DONE, lasting exactly one cycle:
  - oDone=1.
  - oCount ← delivered; oShort ← (delivered < BURST).
  - oAddr ← oAddr + delivered, modulo 2^AW.
  - Then go to IDLE.
- iCall is ignored in XFER and DONE; there is no queuing.
- oCount, oShort and oAddr hold their values until the next DONE.
- The block never asserts oFifoEn when iTag[0]=1, so it cannot underflow the FIFO.
- iTag[1] is informational only and is not used by the FSM.
- The FIFO is never read outside XFER.
- A word is always delivered before the burst ends:
  - The GRACE exit requires oValid=0.
  - A held word under backpressure extends XFER indefinitely.

## Timing
- Reset values: oDone=0, oFifoEn=0, oValid=0, oData=0, oCount=0, oShort=0, oAddr=0, state IDLE.
- Assertion of RESET mid-burst aborts at once:
  - In-flight oData is discarded.
  - oDone is not pulsed.
  - FIFO words already read are lost; this is accepted.
- Latency:
  - iCall sampled at edge T puts the FSM in XFER during cycle T+1.
  - The first oFifoEn can assert in cycle T+1; the first oValid=1 comes in cycle T+2.
- Throughput is 1 word per cycle while the FIFO is non-empty and iReady=1. A load and an accept in the same cycle keep oValid=1 with the new word.
- With a full FIFO and iReady held at 1, a BURST=8 call gives:
  - oValid high for cycles T+2 … T+9,
  - DONE in cycle T+10,
  - IDLE in T+11.
- Short burst with the FIFO empty from the start: the empty counter reaches GRACE after GRACE XFER cycles, then DONE follows with oCount=0.

## Test plan
- FIFO preloaded with 0x0001–0x0010, iReady=1, iCall pulse:
  - 8 words 0x0001–0x0008 appear on consecutive cycles.
  - oDone pulses once with oCount=8, oShort=0, oAddr=8.
  - The FIFO is left holding 8 words.
- Same preload, iReady toggling 1,0,1,0:
  - Each word is held stable while iReady=0.
  - No word is lost or duplicated; 8 words are delivered, and oFifoEn is never high while oValid=1 & iReady=0.
- Empty FIFO, GRACE=4, iCall:
  - No oFifoEn at any point.
  - oDone comes 4 XFER cycles later with oCount=0, oShort=1, oAddr unchanged.
- FIFO holding 3 words, then 2 more written 2 cycles after the drain:
  - All 5 are delivered; the empty counter resets on the first new load.
  - After GRACE idle cycles: oCount=5, oShort=1.
- Wrap-around with AW=4 and oAddr=12: a full burst of 8 leaves oAddr=4.
- Robustness, two cases:
  - iCall re-asserted during XFER has no effect and yields exactly one oDone.
  - RESET pulsed mid-burst returns every output to its reset value asynchronously, and no oDone appears.

Source files
------------

// File: rtl/fifo_drainmod.sv
// fifo_drainmod
// Read-side controller for the show-ahead save FIFO. Each iCall drains up to
// BURST words from the FIFO into a valid/ready stream. It keeps a running word
// address for the SDRAM write path. A burst ends early once the FIFO has been
// empty for GRACE consecutive cycles while no word is held.
//
// Ports:
//   CLOCK      system clock, rising edge
//   RESET      asynchronous, active-low reset
//   iCall      start one burst (sampled only in IDLE)
//   oDone      one-cycle pulse when the burst finishes
//   iTag       FIFO status: [1] full (unused), [0] empty
//   iFifoData  FIFO head word, valid whenever iTag[0]=0
//   oFifoEn    FIFO read strobe
//   oData      stream data
//   oValid     oData holds an undelivered word
//   iReady     consumer accepts oData this cycle
//   oCount     words delivered in the last completed burst
//   oShort     last burst ended early with fewer than BURST words
//   oAddr      word address for the next burst's first word
module fifo_drainmod #(
    parameter int BURST = 8,
    parameter int GRACE = 4,
    parameter int AW    = 22
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic          iCall,
    output logic          oDone,
    input  logic [1:0]    iTag,
    input  logic [15:0]   iFifoData,
    output logic          oFifoEn,
    output logic [15:0]   oData,
    output logic          oValid,
    input  logic          iReady,
    output logic [8:0]    oCount,
    output logic          oShort,
    output logic [AW-1:0] oAddr
);

    localparam logic [8:0] BURST_W = 9'(BURST);
    localparam logic [7:0] GRACE_W = 8'(GRACE);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    state_t     stateReg;
    state_t     stateNext;
    logic [8:0] issuedReg;
    logic [8:0] deliveredReg;
    logic [7:0] emptyReg;

    logic       inXfer;
    logic       canIssue;
    logic       load;
    logic       accept;
    logic [8:0] deliveredNext;
    logic [7:0] emptyNext;

    // The full flag is informational only.
    logic       unusedFull;
    assign unusedFull = iTag[1];

    always_comb begin
        stateNext     = stateReg;
        oDone         = 1'b0;
        inXfer        = (stateReg == XFER);
        canIssue      = (issuedReg < BURST_W);
        // A new word may be loaded when the output slot is free or is being
        // emptied in this same cycle.
        load          = inXfer & canIssue & ~iTag[0] & (~oValid | iReady);
        accept        = inXfer & oValid & iReady;
        oFifoEn       = load;
        deliveredNext = deliveredReg + {8'd0, accept};
        emptyNext     = emptyReg;
        if (load) begin
            emptyNext = 8'd0;
        end else if (inXfer && canIssue && iTag[0] && !oValid && emptyReg < GRACE_W) begin
            emptyNext = emptyReg + 8'd1;
        end

        case (stateReg)
            IDLE: begin
                if (iCall) begin
                    stateNext = XFER;
                end
            end
            XFER: begin
                // Exit on the updated counters, so that DONE follows directly
                // after the last accept or the last empty cycle. The empty
                // counter only advances when no word is held, so the grace exit
                // never drops a word.
                if (deliveredNext == BURST_W || emptyNext == GRACE_W) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                oDone     = 1'b1;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            stateReg     <= IDLE;
            issuedReg    <= 9'd0;
            deliveredReg <= 9'd0;
            emptyReg     <= 8'd0;
            oData        <= 16'd0;
            oValid       <= 1'b0;
            oCount       <= 9'd0;
            oShort       <= 1'b0;
            oAddr        <= '0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: begin
                    issuedReg    <= 9'd0;
                    deliveredReg <= 9'd0;
                    emptyReg     <= 8'd0;
                end
                XFER: begin
                    if (load) begin
                        oData     <= iFifoData;
                        oValid    <= 1'b1;
                        issuedReg <= issuedReg + 9'd1;
                    end else if (accept) begin
                        oValid <= 1'b0;
                    end
                    deliveredReg <= deliveredNext;
                    emptyReg     <= emptyNext;
                end
                DONE: begin
                    oCount <= deliveredReg;
                    oShort <= (deliveredReg < BURST_W);
                    // Truncation to AW bits gives the modulo-2^AW wrap.
                    oAddr  <= oAddr + AW'(deliveredReg);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_drainmod.sv
// Testbench for fifo_drainmod. It uses BURST=8, GRACE=4 and AW=4, so that the
// address wrap is easy to reach. The bench models the FIFO as a queue. The
// expected stream is every word pushed, in push order. Burst outcomes come
// from simple rules: the count is min(words available, BURST), and the address
// advances by the count modulo 16.
module tb_fifo_drainmod;

    localparam int BURST = 8;
    localparam int GRACE = 4;
    localparam int AW    = 4;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          iCall;
    logic          oDone;
    logic [1:0]    iTag;
    logic [15:0]   iFifoData;
    logic          oFifoEn;
    logic [15:0]   oData;
    logic          oValid;
    logic          iReady;
    logic [8:0]    oCount;
    logic          oShort;
    logic [AW-1:0] oAddr;

    fifo_drainmod #(.BURST(BURST), .GRACE(GRACE), .AW(AW)) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .iCall    (iCall),
        .oDone    (oDone),
        .iTag     (iTag),
        .iFifoData(iFifoData),
        .oFifoEn  (oFifoEn),
        .oData    (oData),
        .oValid   (oValid),
        .iReady   (iReady),
        .oCount   (oCount),
        .oShort   (oShort),
        .oAddr    (oAddr)
    );

    always #5 CLOCK = ~CLOCK;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] fifoQ[$];
    logic [15:0] expStream[$];
    logic [15:0] wordCtr;
    int          addrModel;
    int          cyc;
    int          accCnt;
    int          doneCnt;
    int          doneCyc;
    bit          inBurst;
    bit          prevHeld;
    logic [15:0] prevData;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic updPins();
        iTag      = {fifoQ.size() >= 1024, fifoQ.size() == 0};
        iFifoData = (fifoQ.size() != 0) ? fifoQ[0] : 16'h0000;
    endtask

    task automatic pushWords(input int n);
        for (int i = 0; i < n; i++) begin
            fifoQ.push_back(wordCtr);
            expStream.push_back(wordCtr);
            wordCtr = wordCtr + 16'd1;
        end
        updPins();
    endtask

    task automatic clearFifo();
        fifoQ.delete();
        expStream.delete();
        wordCtr = 16'h0001;
        updPins();
    endtask

    // One clock cycle: sample at the falling edge, then pop the model FIFO
    // after the rising edge if the DUT strobed it.
    task automatic step();
        bit pop;
        @(negedge CLOCK);
        chk("no_underflow", {31'd0, oFifoEn & (fifoQ.size() == 0)}, 32'd0);
        chk("no_read_backpressure", {31'd0, oFifoEn & oValid & ~iReady}, 32'd0);
        chk("no_read_outside_burst", {31'd0, oFifoEn & ~inBurst}, 32'd0);
        if (prevHeld) begin
            chk("hold_valid", {31'd0, oValid}, 32'd1);
            chk("hold_data", {16'd0, oData}, {16'd0, prevData});
        end
        if (oValid && iReady) begin
            chk("stream_nonempty", {31'd0, expStream.size() != 0}, 32'd1);
            if (expStream.size() != 0) begin
                chk("stream_data", {16'd0, oData}, {16'd0, expStream[0]});
                void'(expStream.pop_front());
            end
            accCnt++;
        end
        if (oDone === 1'b1) begin
            doneCnt++;
            doneCyc = cyc;
        end
        pop      = (oFifoEn === 1'b1);
        prevHeld = (oValid === 1'b1) && (iReady === 1'b0);
        prevData = oData;
        @(posedge CLOCK);
        #1;
        if (pop && fifoQ.size() != 0) void'(fifoQ.pop_front());
        updPins();
        cyc++;
    endtask

    // readyMode: 0 = always 1, 1 = toggle 1,0,1,0, 2 = random.
    task automatic burst(input string name, input int readyMode, input int pushAt,
                         input int pushN, input int callAgainFrom, input int expCnt,
                         input int expDoneCyc);
        accCnt  = 0;
        doneCnt = 0;
        doneCyc = -1;
        cyc     = 0;
        while (doneCnt == 0 && cyc < 300) begin
            iCall   = (cyc == 0) ||
                      (callAgainFrom >= 0 && cyc >= callAgainFrom && cyc < callAgainFrom + 4);
            case (readyMode)
                0:       iReady = 1'b1;
                1:       iReady = (cyc % 2 == 0);
                default: iReady = 1'($urandom_range(0, 1));
            endcase
            if (cyc == pushAt) pushWords(pushN);
            inBurst = (cyc >= 1);
            step();
        end
        iCall   = 1'b0;
        iReady  = 1'b1;
        inBurst = 1'b0;
        addrModel = (addrModel + expCnt) % 16;
        chk({name, "_done_once"}, doneCnt, 1);
        chk({name, "_delivered"}, accCnt, expCnt);
        chk({name, "_oCount"}, {23'd0, oCount}, expCnt);
        chk({name, "_oShort"}, {31'd0, oShort}, {31'd0, expCnt < BURST});
        chk({name, "_oAddr"}, {28'd0, oAddr}, addrModel);
        if (expDoneCyc >= 0) chk({name, "_done_cycle"}, doneCyc, expDoneCyc);
        step();
        chk({name, "_no_second_done"}, doneCnt, 1);
        $display("burst %s: delivered=%0d oCount=%0d oShort=%0b oAddr=%0d doneCycle=%0d",
                 name, accCnt, oCount, oShort, oAddr, doneCyc);
    endtask

    initial begin
        int n;
        int e;
        RESET     = 1'b0;
        iCall     = 1'b0;
        iReady    = 1'b0;
        inBurst   = 1'b0;
        prevHeld  = 1'b0;
        prevData  = 16'h0;
        addrModel = 0;
        clearFifo();
        repeat (2) @(negedge CLOCK);
        chk("reset_oDone", {31'd0, oDone}, 32'd0);
        chk("reset_oFifoEn", {31'd0, oFifoEn}, 32'd0);
        chk("reset_oValid", {31'd0, oValid}, 32'd0);
        chk("reset_oData", {16'd0, oData}, 32'd0);
        chk("reset_oCount", {23'd0, oCount}, 32'd0);
        chk("reset_oShort", {31'd0, oShort}, 32'd0);
        chk("reset_oAddr", {28'd0, oAddr}, 32'd0);
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        step();

        // Full FIFO, iReady held high: exact latency, 8 words, 8 left behind.
        pushWords(16);
        burst("full", 0, -1, 0, -1, 8, 10);
        chk("full_fifo_left", fifoQ.size(), 8);

        // Same preload with iReady toggling: words held under backpressure.
        clearFifo();
        pushWords(16);
        burst("toggle", 1, -1, 0, -1, 8, -1);

        // Empty FIFO: grace expiry after GRACE XFER cycles, nothing read.
        clearFifo();
        burst("empty", 0, -1, 0, -1, 0, 1 + GRACE);

        // Three words, two more arrive later; the grace count restarts.
        clearFifo();
        pushWords(3);
        burst("late_words", 0, 6, 2, -1, 5, -1);

        // Seven words with random backpressure brings the address to 12.
        clearFifo();
        pushWords(7);
        burst("seven", 2, -1, 0, -1, 7, -1);
        chk("addr_before_wrap", {28'd0, oAddr}, 32'd12);

        // Full burst wraps 12+8 to 4; a repeated iCall mid-burst is ignored.
        pushWords(10);
        burst("wrap_recall", 0, -1, 0, 3, 8, 10);
        chk("addr_after_wrap", {28'd0, oAddr}, 32'd4);

        // Random fills and backpressure; leftovers carry into the next call.
        for (int r = 0; r < 5; r++) begin
            n = $urandom_range(0, 12);
            pushWords(n);
            e = (fifoQ.size() > BURST) ? BURST : fifoQ.size();
            burst("random", 2, -1, 0, -1, e, -1);
        end

        // Reset mid-burst: outputs clear asynchronously, no done pulse.
        clearFifo();
        pushWords(16);
        accCnt  = 0;
        doneCnt = 0;
        cyc     = 0;
        iReady  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iCall   = (i == 0);
            inBurst = (i >= 1);
            step();
        end
        iCall = 1'b0;
        @(negedge CLOCK);
        #1;
        RESET = 1'b0;
        #1;
        chk("abort_oValid", {31'd0, oValid}, 32'd0);
        chk("abort_oData", {16'd0, oData}, 32'd0);
        chk("abort_oDone", {31'd0, oDone}, 32'd0);
        chk("abort_oFifoEn", {31'd0, oFifoEn}, 32'd0);
        chk("abort_oCount", {23'd0, oCount}, 32'd0);
        chk("abort_oShort", {31'd0, oShort}, 32'd0);
        chk("abort_oAddr", {28'd0, oAddr}, 32'd0);
        prevHeld = 1'b0;
        inBurst  = 1'b0;
        @(posedge CLOCK);
        #1;
        clearFifo();
        step();
        step();
        RESET = 1'b1;
        for (int i = 0; i < 12; i++) step();
        chk("abort_no_done", doneCnt, 0);
        $display("burst abort: delivered=%0d doneCount=%0d oAddr=%0d", accCnt, doneCnt, oAddr);
        addrModel = 0;

        // A normal burst after the abort.
        pushWords(10);
        burst("after_reset", 0, -1, 0, -1, 8, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
